// File: rtl/cpu_clock_reset_sequencer.sv
// CPU clock/reset sequencer for the MiniSRC core.
//
// Holds the CPU in reset until the PLL has been continuously locked for
// LOCK_HOLD_CYCLES cycles, debounces the reset and single-step pushbuttons,
// and produces a registered clock enable for free-run or single-step use.
//
// Ports:
//   clk         - CPU clock (PLL outclk_0)
//   rst_n       - board reset, async assert, released synchronously inside
//   pll_locked  - PLL lock flag, asynchronous
//   btn_reset_n - CPU reset pushbutton, active-low, bouncy, asynchronous
//   btn_step_n  - single-step pushbutton, active-low, bouncy, asynchronous
//   step_mode   - 1 = single-step, 0 = free-run, asynchronous
//   cpu_rst_n   - active-low CPU reset (flop output)
//   cpu_clk_en  - CPU clock enable (flop output)
//   seq_state   - sequencer state for debug LEDs (0 hold, 1 wait, 2 run)

module cpu_clock_reset_sequencer #(
    parameter int unsigned LOCK_HOLD_CYCLES = 1024,
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       btn_reset_n,
    input  logic       btn_step_n,
    input  logic       step_mode,
    output logic       cpu_rst_n,
    output logic       cpu_clk_en,
    output logic [1:0] seq_state
);

    localparam int unsigned HoldW = $clog2(LOCK_HOLD_CYCLES);
    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LOCK_HOLD_CYCLES - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned BtnReset = 0;
    localparam int unsigned BtnStep  = 1;

    typedef enum logic [1:0] {
        StHold = 2'd0,
        StWait = 2'd1,
        StRun  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Board reset: asserts asynchronously, releases on a clock edge
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic                   rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] rbtn_sync_q;
    logic [SYNC_STAGES-1:0] sbtn_sync_q;
    logic [SYNC_STAGES-1:0] mode_sync_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_sync_q <= '0;
            rbtn_sync_q <= '1;
            sbtn_sync_q <= '1;
            mode_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
            rbtn_sync_q <= {rbtn_sync_q[SYNC_STAGES-2:0], btn_reset_n};
            sbtn_sync_q <= {sbtn_sync_q[SYNC_STAGES-2:0], btn_step_n};
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], step_mode};
        end
    end

    logic       lock_s;
    logic       mode_s;
    logic [1:0] btn_level;

    assign lock_s    = lock_sync_q[SYNC_STAGES-1];
    assign mode_s    = mode_sync_q[SYNC_STAGES-1];
    assign btn_level = {sbtn_sync_q[SYNC_STAGES-1], rbtn_sync_q[SYNC_STAGES-1]};

    // ------------------------------------------------------------------
    // Pushbutton debounce: a new level is accepted only after it has
    // differed from the debounced level for DEBOUNCE_CYCLES straight cycles.
    // press_q pulses for one cycle on an accepted 1->0 transition.
    // ------------------------------------------------------------------
    logic [1:0]      btn_deb_q;
    logic [1:0]      press_q;
    logic [DebW-1:0] deb_cnt_q [2];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            btn_deb_q <= 2'b11;
            press_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_q[i] <= 1'b0;
                if (btn_level[i] == btn_deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebLast) begin
                    btn_deb_q[i] <= btn_level[i];
                    deb_cnt_q[i] <= '0;
                    press_q[i]   <= ~btn_level[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    logic rst_press;
    logic step_press;

    assign rst_press  = press_q[BtnReset];
    assign step_press = press_q[BtnStep];

    // ------------------------------------------------------------------
    // Sequencer FSM with registered reset and clock-enable outputs.
    // Lock loss beats a reset press; a reset press beats a step press.
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic             cpu_rst_n_q;
    logic             cpu_clk_en_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= StHold;
            hold_cnt_q   <= '0;
            cpu_rst_n_q  <= 1'b0;
            cpu_clk_en_q <= 1'b0;
        end else begin
            cpu_clk_en_q <= 1'b0;
            unique case (state_q)
                StHold: begin
                    if (lock_s) begin
                        state_q    <= StWait;
                        hold_cnt_q <= '0;
                    end
                end
                StWait: begin
                    if (!lock_s) begin
                        state_q <= StHold;
                    end else if (rst_press) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_q     <= StRun;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_q     <= StHold;
                        cpu_rst_n_q <= 1'b0;
                    end else if (rst_press) begin
                        state_q     <= StWait;
                        hold_cnt_q  <= '0;
                        cpu_rst_n_q <= 1'b0;
                    end else begin
                        // Step presses are pulses, never stored, so anything
                        // arriving outside RUN or in free-run simply vanishes.
                        cpu_clk_en_q <= !mode_s || step_press;
                    end
                end
                default: begin
                    state_q     <= StHold;
                    cpu_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign cpu_clk_en = cpu_clk_en_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_cpu_clock_reset_sequencer.sv
module tb_cpu_clock_reset_sequencer;

    localparam int unsigned LockHold   = 8;
    localparam int unsigned Debounce   = 4;
    localparam int unsigned SyncStages = 2;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       btn_reset_n;
    logic       btn_step_n;
    logic       step_mode;
    logic       cpu_rst_n;
    logic       cpu_clk_en;
    logic [1:0] seq_state;

    int n_checks;
    int n_fail;

    cpu_clock_reset_sequencer #(
        .LOCK_HOLD_CYCLES(LockHold),
        .DEBOUNCE_CYCLES (Debounce),
        .SYNC_STAGES     (SyncStages)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .btn_reset_n(btn_reset_n),
        .btn_step_n (btn_step_n),
        .step_mode  (step_mode),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_clk_en (cpu_clk_en),
        .seq_state  (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference: inputs are delayed through FIFOs, buttons are
    // accepted after Debounce consecutive disagreeing samples, and the
    // sequencer counts completed WAIT cycles up to LockHold.
    // ------------------------------------------------------------------
    bit          m_lock_q[$];
    bit          m_rbtn_q[$];
    bit          m_sbtn_q[$];
    bit          m_mode_q[$];
    int unsigned m_state;
    int unsigned m_waited;
    int unsigned m_rrun;
    int unsigned m_srun;
    bit          m_rdeb;
    bit          m_sdeb;
    bit          m_rp;
    bit          m_sp;
    bit          m_rst;
    bit          m_en;

    function automatic void model_reset();
        m_lock_q.delete();
        m_rbtn_q.delete();
        m_sbtn_q.delete();
        m_mode_q.delete();
        for (int i = 0; i < int'(SyncStages); i++) begin
            m_lock_q.push_back(1'b0);
            m_rbtn_q.push_back(1'b1);
            m_sbtn_q.push_back(1'b1);
            m_mode_q.push_back(1'b0);
        end
        m_state  = 0;
        m_waited = 0;
        m_rrun   = 0;
        m_srun   = 0;
        m_rdeb   = 1'b1;
        m_sdeb   = 1'b1;
        m_rp     = 1'b0;
        m_sp     = 1'b0;
        m_rst    = 1'b0;
        m_en     = 1'b0;
    endfunction

    function automatic void model_step();
        bit lk, rb, sb, md, rp_now, sp_now;
        m_lock_q.push_back(pll_locked);
        m_rbtn_q.push_back(btn_reset_n);
        m_sbtn_q.push_back(btn_step_n);
        m_mode_q.push_back(step_mode);
        lk = m_lock_q.pop_front();
        rb = m_rbtn_q.pop_front();
        sb = m_sbtn_q.pop_front();
        md = m_mode_q.pop_front();
        m_en = 1'b0;
        case (m_state)
            0: if (lk) begin m_state = 1; m_waited = 0; end
            1: begin
                if (!lk) m_state = 0;
                else if (m_rp) m_waited = 0;
                else begin
                    m_waited++;
                    if (m_waited == LockHold) m_state = 2;
                end
            end
            2: begin
                if (!lk) m_state = 0;
                else if (m_rp) begin m_state = 1; m_waited = 0; end
                else m_en = !md || m_sp;
            end
            default: m_state = 0;
        endcase
        m_rst  = (m_state == 2);
        rp_now = 1'b0;
        sp_now = 1'b0;
        if (rb == m_rdeb) m_rrun = 0;
        else begin
            m_rrun++;
            if (m_rrun == Debounce) begin m_rdeb = rb; m_rrun = 0; rp_now = !rb; end
        end
        if (sb == m_sdeb) m_srun = 0;
        else begin
            m_srun++;
            if (m_srun == Debounce) begin m_sdeb = sb; m_srun = 0; sp_now = !sb; end
        end
        m_rp = rp_now;
        m_sp = sp_now;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_rst_n, cpu_clk_en, seq_state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async: rst_n=%b en=%b state=%0d, expected 0 0 0",
                     cpu_rst_n, cpu_clk_en, seq_state);
        end
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_checks++;
            if ({cpu_rst_n, cpu_clk_en, seq_state} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold edge %0d: rst_n=%b en=%b state=%0d, expected 0 0 0",
                         e, cpu_rst_n, cpu_clk_en, seq_state);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_power_up();
        logic [1:0] exp_seq;
        logic       exp_rst, exp_en;
        for (int e = 6; e <= 10; e++) begin
            tick();
            n_checks++;
            if ({cpu_rst_n, cpu_clk_en, seq_state} !== 4'b0000) begin
                n_fail++;
                $display("FAIL power_up_idle edge %0d: rst_n=%b en=%b state=%0d, expected 0 0 0",
                         e, cpu_rst_n, cpu_clk_en, seq_state);
            end
        end
        pll_locked = 1'b1;
        for (int e = 11; e <= 24; e++) begin
            tick();
            exp_seq = (e < 13) ? 2'd0 : (e < 21) ? 2'd1 : 2'd2;
            exp_rst = (e >= 21);
            exp_en  = (e >= 22);
            n_checks++;
            if ({cpu_rst_n, cpu_clk_en, seq_state} !== {exp_rst, exp_en, exp_seq}) begin
                n_fail++;
                $display("FAIL power_up edge %0d: rst_n=%b en=%b state=%0d, expected %b %b %0d",
                         e, cpu_rst_n, cpu_clk_en, seq_state, exp_rst, exp_en, exp_seq);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [1:0] exp_seq;
        logic       exp_rst, exp_en;
        tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) tick();
            exp_seq = (k < 3) ? 2'd2 : (k == 3) ? 2'd0 : (k < 12) ? 2'd1 : 2'd2;
            exp_rst = (k < 3) || (k >= 12);
            exp_en  = (k < 3) || (k >= 13);
            n_checks++;
            if ({cpu_rst_n, cpu_clk_en, seq_state} !== {exp_rst, exp_en, exp_seq}) begin
                n_fail++;
                $display("FAIL lock_loss N+%0d: rst_n=%b en=%b state=%0d, expected %b %b %0d",
                         k, cpu_rst_n, cpu_clk_en, seq_state, exp_rst, exp_en, exp_seq);
            end
        end
    endtask

    task automatic test_bounce();
        int low_cycles;
        logic exp_rst, exp_en;
        for (int i = 0; i < 10; i++) begin
            btn_reset_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                tick();
                n_checks++;
                if (cpu_rst_n !== 1'b1 || cpu_clk_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce_reject: rst_n=%b en=%b, expected 1 1",
                             cpu_rst_n, cpu_clk_en);
                end
            end
        end
        btn_reset_n = 1'b1;
        repeat (10) tick();
        btn_reset_n = 1'b0;
        low_cycles  = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) btn_reset_n = 1'b1;
            exp_rst = !(k >= 7 && k < 15);
            exp_en  = (k < 7) || (k >= 16);
            if (cpu_rst_n === 1'b0) low_cycles++;
            n_checks++;
            if (cpu_rst_n !== exp_rst || cpu_clk_en !== exp_en) begin
                n_fail++;
                $display("FAIL bounce_press P+%0d: rst_n=%b en=%b, expected %b %b",
                         k, cpu_rst_n, cpu_clk_en, exp_rst, exp_en);
            end
        end
        n_checks++;
        if (low_cycles != 8) begin
            n_fail++;
            $display("FAIL bounce_reset_width: %0d cycles low, expected 8", low_cycles);
        end
    endtask

    task automatic test_single_step();
        int pulses;
        step_mode = 1'b1;
        repeat (6) tick();
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            btn_step_n = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (k == 12) btn_step_n = 1'b1;
                if (cpu_clk_en === 1'b1) pulses++;
                n_checks++;
                if (cpu_clk_en !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL single_step press %0d P+%0d: en=%b, expected %b",
                             p, k, cpu_clk_en, (k == 7));
                end
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL single_step_count: %0d pulses, expected 3", pulses);
        end
    endtask

    task automatic test_mode_switch();
        step_mode = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (cpu_clk_en !== (k >= 3)) begin
                n_fail++;
                $display("FAIL mode_switch M+%0d: en=%b, expected %b", k, cpu_clk_en, (k >= 3));
            end
        end
    endtask

    task automatic test_collisions();
        logic [1:0] exp_seq;
        step_mode = 1'b1;
        repeat (5) tick();
        // Step press that matures while the sequencer is in WAIT
        btn_reset_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 3)  btn_step_n  = 1'b0;
            if (k == 10) btn_reset_n = 1'b1;
            if (k == 13) btn_step_n  = 1'b1;
            exp_seq = (k >= 7 && k < 15) ? 2'd1 : 2'd2;
            n_checks++;
            if (cpu_clk_en !== 1'b0 || seq_state !== exp_seq || cpu_rst_n !== (exp_seq == 2'd2)) begin
                n_fail++;
                $display("FAIL step_in_wait P+%0d: en=%b state=%0d rst_n=%b, expected 0 %0d %b",
                         k, cpu_clk_en, seq_state, cpu_rst_n, exp_seq, (exp_seq == 2'd2));
            end
        end
        // Reset and step pressed together
        btn_reset_n = 1'b0;
        btn_step_n  = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 10) begin
                btn_reset_n = 1'b1;
                btn_step_n  = 1'b1;
            end
            exp_seq = (k >= 7 && k < 15) ? 2'd1 : 2'd2;
            n_checks++;
            if (cpu_clk_en !== 1'b0 || seq_state !== exp_seq || cpu_rst_n !== (exp_seq == 2'd2)) begin
                n_fail++;
                $display("FAIL simultaneous P+%0d: en=%b state=%0d rst_n=%b, expected 0 %0d %b",
                         k, cpu_clk_en, seq_state, cpu_rst_n, exp_seq, (exp_seq == 2'd2));
            end
        end
    endtask

    task automatic test_async_reset();
        int t;
        int waited;
        step_mode = 1'b0;
        repeat (5) tick();
        btn_reset_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) btn_reset_n = 1'b1;
        end
        n_checks++;
        if (seq_state !== 2'd1) begin
            n_fail++;
            $display("FAIL async_pre_wait: state=%0d, expected 1", seq_state);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_rst_n, cpu_clk_en, seq_state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_mid_wait: rst_n=%b en=%b state=%0d, expected 0 0 0",
                     cpu_rst_n, cpu_clk_en, seq_state);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        t = 0;
        while (seq_state !== 2'd1 && t < 20) begin
            tick();
            t++;
        end
        n_checks++;
        if (seq_state !== 2'd1) begin
            n_fail++;
            $display("FAIL async_rewait_entry: state=%0d, expected 1 within 20 cycles", seq_state);
        end
        waited = 0;
        while (seq_state === 2'd1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (waited != 8 || seq_state !== 2'd2 || cpu_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rewait: waited=%0d state=%0d rst_n=%b, expected 8 2 1",
                     waited, seq_state, cpu_rst_n);
        end
        // Assertion in RUN must drop the reset output without any edge
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cpu_rst_n, cpu_clk_en, seq_state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_mid_run: rst_n=%b en=%b state=%0d, expected 0 0 0",
                     cpu_rst_n, cpu_clk_en, seq_state);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_random();
        int lock_left, rbtn_left, sbtn_left, mode_left;
        rst_n       = 1'b0;
        pll_locked  = 1'b0;
        btn_reset_n = 1'b1;
        btn_step_n  = 1'b1;
        step_mode   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        model_reset();
        lock_left = 3;
        rbtn_left = 40;
        sbtn_left = 5;
        mode_left = 100;
        for (int c = 0; c < 3000; c++) begin
            if (lock_left == 0) begin
                pll_locked = ~pll_locked;
                lock_left  = pll_locked ? int'($urandom_range(30, 300)) : int'($urandom_range(1, 12));
            end else lock_left--;
            if (rbtn_left == 0) begin
                btn_reset_n = ~btn_reset_n;
                rbtn_left   = btn_reset_n ? int'($urandom_range(30, 200)) : int'($urandom_range(1, 8));
            end else rbtn_left--;
            if (sbtn_left == 0) begin
                btn_step_n = ~btn_step_n;
                sbtn_left  = int'($urandom_range(1, 25));
            end else sbtn_left--;
            if (mode_left == 0) begin
                step_mode = ~step_mode;
                mode_left = int'($urandom_range(50, 400));
            end else mode_left--;
            @(posedge clk);
            model_step();
            #1;
            n_checks++;
            if ({cpu_rst_n, cpu_clk_en, seq_state} !== {m_rst, m_en, 2'(m_state)}) begin
                n_fail++;
                $display("FAIL random cycle %0d: rst_n=%b en=%b state=%0d, expected %b %b %0d",
                         c, cpu_rst_n, cpu_clk_en, seq_state, m_rst, m_en, m_state);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b1;
        pll_locked  = 1'b0;
        btn_reset_n = 1'b1;
        btn_step_n  = 1'b1;
        step_mode   = 1'b0;
        #2;
        test_reset();
        test_power_up();
        test_lock_loss();
        test_bounce();
        test_single_step();
        test_mode_switch();
        test_collisions();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
